key_event_queue: RTL and testbench
==================================

// Module: key_event_queue
// PURPOSE
//  Consumer side of the debounced key interface. Takes the 5 debounced key
//  levels, which come from the slow divided-clock domain, and synchronises
//  them into clk. It detects press edges and encodes each press as a key code.
//  Codes are queued in a small FIFO and handed to the game FSM over a
//  valid/ready handshake, so no press is lost while the FSM is busy moving tiles.
// PARAMETERS
//  NKEYS          5     number of key lines; key index i maps to code i+1
//  DEPTH          4     FIFO entries; must be a power of 2, >= 2
//  REPEAT_DELAY   2**20 hold cycles before the first auto-repeat (KEY_REPEAT_EN only)
//  REPEAT_PERIOD  2**18 cycles between later repeats (KEY_REPEAT_EN only)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous reset, active-low
//  key_level   in   NKEYS  debounced key levels, 1 = pressed; asynchronous to clk
//  evt_valid   out  1      head of FIFO holds an event
//  evt_code    out  3      code of the head event (1..NKEYS); 0 when evt_valid=0
//  evt_repeat  out  1      head event is an auto-repeat, not a fresh press
//  evt_ready   in   1      consumer accepts the head when evt_valid && evt_ready
//  overflow    out  1      sticky: an event was dropped because the FIFO was full
//  collision   out  1      sticky: more than one key rose in the same cycle
// BEHAVIOUR
//  - Reset (rst=0, asynchronous):
//      sync regs and prev reg = 0; FIFO empty;
//      evt_valid, evt_code, evt_repeat, overflow and collision = 0.
//  - Synchroniser: key_level -> s1 -> s2 (2 flops); prev <= s2 every cycle.
//  - Press detect: rise = s2 & ~prev.
//      Lowest set index wins; its code is pushed.
//      Any other set bits are dropped and set collision.
//  - Latency: key_level goes high before edge E0. evt_valid is high after
//    edge E2 (s1@E0, s2@E1, push@E2), when the FIFO was empty and not full.
//  - Release edges produce no event.
//  - FIFO: wr/rd pointers are log2(DEPTH)+1 bits and wrap naturally.
//      full:  pointers differ only in the MSB.
//      empty: pointers are equal.
//      pop = evt_valid & evt_ready.
//  - Full with no pop: the push is discarded, overflow <= 1, contents unchanged.
//  - Full with a simultaneous pop: the push is accepted; the count stays at DEPTH.
//  - Empty with evt_ready=1: no effect.
//  - The head is not bypassed: a push into an empty FIFO shows on evt_valid
//    one edge later.
//  - evt_code and evt_repeat are driven combinationally from the head entry.
//  - Once evt_valid is asserted, it and the head stay stable until popped.
//  - overflow and collision clear only on reset.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//   - A 21-bit hold counter runs while s2 has exactly one bit set and
//     s2 == prev.
//   - The counter clears on any change of s2, and whenever zero or several
//     keys are held.
//   - When it reaches REPEAT_DELAY-1, the held key's code is pushed with
//     repeat=1.
//   - After that, a repeat is pushed every REPEAT_PERIOD cycles while the key
//     stays held.
//   - A repeat push is subject to the same full/overflow rule as a press.
//   - A press edge and a repeat cannot coincide, because the counter is clear
//     on any edge cycle.
//  KEY_REPEAT_EN undefined:
//   - No hold counter is built; only press edges are pushed.
//   - evt_repeat is tied to 0; the REPEAT_* parameters are unused.
// STRUCTURE
//  - Package key_evt_pkg holds:
//      typedef key_code_t (3 bits);
//      constants KEY_NONE=0, KEY_UP=1, KEY_DOWN=2, KEY_LEFT=3, KEY_RIGHT=4,
//      KEY_CENTER=5;
//      typedef key_evt_t {key_code_t code; logic repeat;}.
//  - One sub-module, key_evt_fifo: a DEPTH-entry key_evt_t FIFO with push,
//    pop, full, empty and head outputs.
//  - Synchroniser, edge detect, priority encode and repeat timer stay in
//    the top module.
// TESTING
//  1. Reset mid-queue:
//     queue 2 events, drop rst for 1 cycle
//     -> evt_valid=0, overflow=0, evt_code=0 immediately (async);
//        the FIFO is empty after rst rises.
//  2. Single press, evt_ready=1:
//     key_level=5'b00010 before E0
//     -> evt_valid=1, evt_code=2 after E2; popped the same cycle; a single event.
//  3. Collision:
//     key_level 0 -> 5'b10100 in one step
//     -> exactly one event, code=3; collision=1.
//  4. Overflow with DEPTH=4 and evt_ready=0:
//     5 separate presses
//     -> 4 events queued in order, overflow=1.
//     Then evt_ready=1 with a press on a pop cycle while full
//     -> that push is accepted and the count stays 4.
//  5. Backpressure:
//     evt_valid=1 and evt_ready=0 for 10 cycles
//     -> evt_code stable throughout; exactly one pop when evt_ready=1.
//  6. KEY_REPEAT_EN with REPEAT_DELAY=8, REPEAT_PERIOD=4:
//     hold key 0 for 20 cycles
//     -> 1 press event (repeat=0), then repeats (repeat=1) 8 cycles and
//        12, 16 cycles after the press.
//     Without the macro -> 1 event only.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared key event types and key code constants for the key event queue.
package key_evt_pkg;

  localparam int unsigned CODE_W = 3;

  typedef logic [CODE_W-1:0] key_code_t;

  localparam key_code_t KEY_NONE   = 3'd0;
  localparam key_code_t KEY_UP     = 3'd1;
  localparam key_code_t KEY_DOWN   = 3'd2;
  localparam key_code_t KEY_LEFT   = 3'd3;
  localparam key_code_t KEY_RIGHT  = 3'd4;
  localparam key_code_t KEY_CENTER = 3'd5;

  // 'repeat' is a reserved word, so the flag is called is_repeat
  typedef struct packed {
    key_code_t code;
    logic      is_repeat;
  } key_evt_t;

endpackage

// File: rtl/key_event_queue_if.sv
// Valid/ready event handshake from the key queue to the game FSM.
interface key_event_queue_if;
  import key_evt_pkg::*;

  logic      evt_valid;
  key_code_t evt_code;
  logic      evt_repeat;
  logic      evt_ready;

  modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);

endinterface

// File: rtl/key_evt_fifo.sv
// DEPTH-entry key event FIFO; a push while full is taken only if a pop frees the head slot.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  key_evt_t din,
  output logic     full_c,
  output logic     empty_c,
  output key_evt_t head_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  key_evt_t      mem [DEPTH];
  logic          do_push_c;
  logic          do_pop_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign head_c    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; entries are only visible between the pointers
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/key_event_queue.sv
// Synchronises debounced key levels, turns press edges into queued key codes.
// Optional auto-repeat of a held key is built when KEY_REPEAT_EN is defined.
module key_event_queue
  import key_evt_pkg::*;
#(
  parameter int unsigned NKEYS         = 5,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_DELAY  = 2**20,
  parameter int unsigned REPEAT_PERIOD = 2**18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NKEYS-1:0]   key_level,
  key_event_queue_if.master  evt,
  output logic               overflow,
  output logic               collision
);

  logic [NKEYS-1:0] s1;
  logic [NKEYS-1:0] s2;
  logic [NKEYS-1:0] prev;
  logic [NKEYS-1:0] rise_c;
  logic             multi_c;
  logic             rpt_fire_c;
  logic             push_c;
  logic             pop_c;
  key_evt_t         push_evt_c;
  logic             full_c;
  logic             empty_c;
  key_evt_t         head_c;

  // Lowest set index wins; index i maps to code i+1
  function automatic key_code_t lowest_code(input logic [NKEYS-1:0] v);
    key_code_t c;
    c = KEY_NONE;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (v[i]) c = key_code_t'(i + 1);
    end
    return c;
  endfunction

  // Two-flop synchroniser plus previous-level register for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= key_level;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise_c  = s2 & ~prev;
  assign multi_c = ($countones(rise_c) > 1);

`ifdef KEY_REPEAT_EN
  localparam int unsigned CNT_W = 21;

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_c;

  assign hold_c     = $onehot(s2) && (s2 == prev);
  assign rpt_fire_c = hold_c && (hold_cnt == CNT_W'(REPEAT_DELAY - 1));

  // After the first repeat the counter is rewound so it hits the same
  // terminal value again every REPEAT_PERIOD cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if (!hold_c) begin
      hold_cnt <= '0;
    end else if (rpt_fire_c) begin
      hold_cnt <= CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  assign evt.evt_repeat = ~empty_c & head_c.is_repeat;
`else
  logic unused_repeat_cfg;

  assign rpt_fire_c        = 1'b0;
  assign evt.evt_repeat    = 1'b0;
  assign unused_repeat_cfg = ^{21'(REPEAT_DELAY), 21'(REPEAT_PERIOD), head_c.is_repeat};
`endif

  // Press edges take precedence; a repeat can only fire on a no-edge cycle
  always_comb begin
    push_c     = 1'b0;
    push_evt_c = '0;
    if (|rise_c) begin
      push_c          = 1'b1;
      push_evt_c.code = lowest_code(rise_c);
    end else if (rpt_fire_c) begin
      push_c               = 1'b1;
      push_evt_c.code      = lowest_code(s2);
      push_evt_c.is_repeat = 1'b1;
    end
  end

  assign pop_c = ~empty_c & evt.evt_ready;

  key_evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (push_evt_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .head_c  (head_c)
  );

  assign evt.evt_valid = ~empty_c;
  assign evt.evt_code  = empty_c ? KEY_NONE : head_c.code;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      if (push_c && full_c && !pop_c) overflow <= 1'b1;
      if (multi_c)                    collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed and randomized bench for key_event_queue against a queue-based reference model.
module tb_key_event_queue;
  import key_evt_pkg::*;

  localparam int unsigned NKEYS   = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned RDELAY  = 8;
  localparam int unsigned RPERIOD = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NKEYS-1:0] key_level = '0;
  logic             overflow;
  logic             collision;

  key_event_queue_if bus ();

  key_event_queue #(
    .NKEYS         (NKEYS),
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPERIOD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_level (key_level),
    .evt       (bus),
    .overflow  (overflow),
    .collision (collision)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_pops = 0;
  int dut_rpts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: event queue plus the last three applied key levels
  typedef struct {
    int code;
    bit rpt;
  } mevt_t;

  mevt_t            mq[$];
  logic [NKEYS-1:0] la, lb, lc;   // levels applied 1, 2, 3 edges ago
  int               run;          // length of the constant-level run ending at lb
  bit               m_ovf;
  bit               m_col;

  function automatic int low_code(input logic [NKEYS-1:0] v);
    for (int i = 0; i < int'(NKEYS); i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    la = '0; lb = '0; lc = '0;
    run = 1;
    m_ovf = 1'b0;
    m_col = 1'b0;
  endtask

  // One clock edge: lvl and rdy are the inputs applied before it
  task automatic model_edge(input logic [NKEYS-1:0] lvl, input bit rdy);
    logic [NKEYS-1:0] rise;
    bit    pop;
    bit    push;
    mevt_t e;
    rise = lb & ~lc;
    pop  = (mq.size() > 0) && rdy;
    push = 1'b0;
    e.code = 0;
    e.rpt  = 1'b0;
    if (rise != '0) begin
      push   = 1'b1;
      e.code = low_code(rise);
      if ($countones(rise) > 1) m_col = 1'b1;
    end
`ifdef KEY_REPEAT_EN
    else if ($onehot(lb) && run >= int'(RDELAY) + 1 &&
             ((run - 1 - int'(RDELAY)) % int'(RPERIOD)) == 0) begin
      push   = 1'b1;
      e.code = low_code(lb);
      e.rpt  = 1'b1;
    end
`endif
    if (push && mq.size() == int'(DEPTH) && !pop) begin
      m_ovf = 1'b1;
      push  = 1'b0;
    end
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(e);
    run = (la == lb) ? run + 1 : 1;
    lc = lb;
    lb = la;
    la = lvl;
  endtask

  task automatic check_all();
    check("valid", bus.evt_valid, mq.size() > 0);
    check("code", bus.evt_code, (mq.size() > 0) ? mq[0].code : 0);
    check("repeat", bus.evt_repeat, (mq.size() > 0) ? mq[0].rpt : 1'b0);
    check("overflow", overflow, m_ovf);
    check("collision", collision, m_col);
  endtask

  task automatic step(input logic [NKEYS-1:0] lvl, input bit rdy);
    key_level     = lvl;
    bus.evt_ready = rdy;
    if (bus.evt_valid && rdy) begin
      dut_pops++;
      if (bus.evt_repeat) dut_rpts++;
    end
    @(posedge clk);
    model_edge(lvl, rdy);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step('0, rdy);
  endtask

  task automatic press(input int idx, input bit rdy);
    step(NKEYS'(1) << idx, rdy);
    step(NKEYS'(1) << idx, rdy);
    step('0, rdy);
    step('0, rdy);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", bus.evt_valid, 1'b0);
    check("rst_async_code", bus.evt_code, KEY_NONE);
    check("rst_async_ovf", overflow, 1'b0);
    check("rst_async_col", collision, 1'b0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  int p0, r0, hold_len;
  logic [NKEYS-1:0] lvl;

  initial begin
    bus.evt_ready = 1'b0;
    model_reset();
    #1;
    check("reset_valid", bus.evt_valid, 1'b0);
    check("reset_code", bus.evt_code, KEY_NONE);
    check("reset_ovf", overflow, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Single press with the consumer always ready
    p0 = dut_pops;
    step(5'b00010, 1'b1);
    step(5'b00010, 1'b1);
    step(5'b00010, 1'b1);
    check("press_valid_e2", bus.evt_valid, 1'b1);
    check("press_code_e2", bus.evt_code, KEY_DOWN);
    step(5'b00010, 1'b1);
    idle(5, 1'b1);
    check("press_one_event", dut_pops - p0, 1);

    // Two keys rising together
    p0 = dut_pops;
    step(5'b10100, 1'b1);
    step(5'b10100, 1'b1);
    step(5'b10100, 1'b1);
    check("col_code", bus.evt_code, KEY_LEFT);
    idle(5, 1'b1);
    check("col_flag", collision, 1'b1);
    check("col_one_event", dut_pops - p0, 1);

    // Overflow: five presses into a four-entry queue with no consumer
    press(0, 1'b0);
    press(1, 1'b0);
    press(3, 1'b0);
    press(4, 1'b0);
    press(2, 1'b0);
    idle(3, 1'b0);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", bus.evt_code, KEY_UP);
    // Press whose push edge coincides with a pop while full
    step(5'b00100, 1'b0);
    step(5'b00100, 1'b0);
    step('0, 1'b1);
    idle(3, 1'b0);
    p0 = dut_pops;
    idle(8, 1'b1);
    check("full_pop_push_count", dut_pops - p0, 4);

    // Backpressure holds the head until the consumer accepts it
    press(4, 1'b0);
    idle(10, 1'b0);
    check("bp_code", bus.evt_code, KEY_CENTER);
    p0 = dut_pops;
    step('0, 1'b1);
    idle(4, 1'b0);
    check("bp_one_pop", dut_pops - p0, 1);
    idle(2, 1'b1);

    // Hold key 0 for 20 cycles
    p0 = dut_pops;
    r0 = dut_rpts;
    for (int i = 0; i < 20; i++) step(5'b00001, 1'b1);
    idle(8, 1'b1);
`ifdef KEY_REPEAT_EN
    check("hold_events", dut_pops - p0, 4);
    check("hold_repeats", dut_rpts - r0, 3);
`else
    check("hold_events", dut_pops - p0, 1);
    check("hold_repeats", dut_rpts - r0, 0);
`endif

    // Reset with events pending
    press(1, 1'b0);
    press(3, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(3, 1'b1);
    check("post_rst_empty", bus.evt_valid, 1'b0);

    // Randomized key activity and consumer backpressure
    for (int blk = 0; blk < 250; blk++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: lvl = '0;
        4, 5, 6, 7: lvl = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
        default:    lvl = NKEYS'($urandom);
      endcase
      hold_len = $urandom_range(1, 14);
      for (int i = 0; i < hold_len; i++) step(lvl, ($urandom_range(0, 3) != 0));
      if (blk == 120) do_reset();
    end
    idle(10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
